// File: rtl/edge_event_arb_if.sv
// Event stream bundle for edge_event_arb: edge pulses and enables in,
// serialized valid/ready event stream and overflow flags out.
interface edge_event_arb_if #(
  parameter int NUM_CH = 4
);
  localparam int ID_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] posedge_in;
  logic [NUM_CH-1:0] negedge_in;
  logic [NUM_CH-1:0] rise_en;
  logic [NUM_CH-1:0] fall_en;
  logic              evt_valid;
  logic              evt_ready;
  logic [ID_W-1:0]   evt_ch;
  logic              evt_rising;
  logic [NUM_CH-1:0] ovf_sticky;
  logic [NUM_CH-1:0] ovf_clr;

  modport slave (
    input  posedge_in, negedge_in, rise_en, fall_en, evt_ready, ovf_clr,
    output evt_valid, evt_ch, evt_rising, ovf_sticky
  );

  modport master (
    output posedge_in, negedge_in, rise_en, fall_en, evt_ready, ovf_clr,
    input  evt_valid, evt_ch, evt_rising, ovf_sticky
  );
endinterface

// File: rtl/edge_event_arb.sv
// Latches per-channel edge events as pending bits and serializes them onto a
// single valid/ready stream with round-robin arbitration and overflow flags.
module edge_event_arb #(
  parameter int NUM_CH = 4
) (
  input logic             clk,
  input logic             rst,
  edge_event_arb_if.slave bus
);
  localparam int ID_W = $clog2(NUM_CH);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t            state;
  logic [NUM_CH-1:0] pend_r, pend_f, pend;
  logic [NUM_CH-1:0] set_r, set_f, clr_r, clr_f, keep_r, keep_f, ovf_hit;
  logic [NUM_CH-1:0] ovf;
  logic [ID_W-1:0]   last, win, cand;
  logic              found, win_rise, load;
  logic              valid_q, rise_q;
  logic [ID_W-1:0]   ch_q;
  int unsigned       idx;

  always_comb begin
    pend  = pend_r | pend_f;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx  = (32'(last) + k) % NUM_CH;
      cand = ID_W'(idx);
      if (!found && pend[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_rise = pend_r[win];
    // A grant happens from IDLE regardless of ready, or on a transfer edge.
    load  = found && (state == IDLE || bus.evt_ready);
    clr_r = '0;
    clr_f = '0;
    if (load) begin
      if (win_rise) clr_r[win] = 1'b1;
      else          clr_f[win] = 1'b1;
    end
    set_r   = bus.posedge_in & bus.rise_en;
    set_f   = bus.negedge_in & bus.fall_en;
    keep_r  = pend_r & ~clr_r;
    keep_f  = pend_f & ~clr_f;
    ovf_hit = (set_r & keep_r) | (set_f & keep_f);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pend_r  <= '0;
      pend_f  <= '0;
      ovf     <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      rise_q  <= 1'b0;
      last    <= ID_W'(NUM_CH - 1);
    end else begin
      pend_r <= keep_r | set_r;
      pend_f <= keep_f | set_f;
      ovf    <= (ovf & ~bus.ovf_clr) | ovf_hit;
      if (load) begin
        state   <= OFFER;
        valid_q <= 1'b1;
        ch_q    <= win;
        rise_q  <= win_rise;
        last    <= win;
      end else if (state == OFFER && bus.evt_ready) begin
        state   <= IDLE;
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.evt_valid  = valid_q;
  assign bus.evt_ch     = ch_q;
  assign bus.evt_rising = rise_q;
  assign bus.ovf_sticky = ovf;
endmodule

// File: tb/tb_edge_event_arb.sv
// Bench for edge_event_arb: directed vector table, corner-case sequences and
// randomized traffic checked cycle by cycle against a behavioural model.
module tb_edge_event_arb;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  edge_event_arb_if #(.NUM_CH(N)) bus ();
  edge_event_arb #(.NUM_CH(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [N-1:0] m_r, m_f, m_ovf;
  int           m_last;
  logic         m_valid;
  int           m_ch;
  logic         m_rise;

  int xfer_q[$];

  typedef struct {
    logic       r;
    logic [3:0] p;
    logic [3:0] n;
    logic       rdy;
    logic       v;
    int         ch;
    logic       rise;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  win;
    bit  found;
    if (rst) begin
      m_r = '0; m_f = '0; m_ovf = '0;
      m_valid = 1'b0; m_ch = 0; m_rise = 1'b0; m_last = N - 1;
      return;
    end
    found = 1'b0;
    win   = 0;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (!found && (m_r[c] || m_f[c])) begin
        found = 1'b1;
        win   = c;
      end
    end
    if (!m_valid || bus.evt_ready) begin
      if (found) begin
        m_valid = 1'b1;
        m_ch    = win;
        m_rise  = m_r[win];
        if (m_r[win]) m_r[win] = 1'b0;
        else          m_f[win] = 1'b0;
        m_last  = win;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      bit hit;
      hit = 1'b0;
      if (bus.posedge_in[i] && bus.rise_en[i]) begin
        if (m_r[i]) hit = 1'b1;
        m_r[i] = 1'b1;
      end
      if (bus.negedge_in[i] && bus.fall_en[i]) begin
        if (m_f[i]) hit = 1'b1;
        m_f[i] = 1'b1;
      end
      m_ovf[i] = hit | (m_ovf[i] & ~bus.ovf_clr[i]);
    end
  endtask

  task automatic cycle();
    if (!rst && bus.evt_valid && bus.evt_ready)
      xfer_q.push_back(int'(bus.evt_ch) * 2 + int'(bus.evt_rising));
    @(posedge clk);
    model_step();
    #1;
    check("model_valid", bus.evt_valid, m_valid);
    if (m_valid) begin
      check("model_ch", bus.evt_ch, m_ch);
      check("model_rising", bus.evt_rising, m_rise);
    end
    check("model_ovf", bus.ovf_sticky, m_ovf);
  endtask

  task automatic drive(input logic [N-1:0] p, input logic [N-1:0] n,
                       input logic [N-1:0] clr, input logic rdy);
    bus.posedge_in = p;
    bus.negedge_in = n;
    bus.ovf_clr    = clr;
    bus.evt_ready  = rdy;
  endtask

  task automatic idle(input int cycles, input logic rdy);
    for (int i = 0; i < cycles; i++) begin
      drive('0, '0, '0, rdy);
      cycle();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, '0, '0, 1'b1);
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.rise_en = '1;
    bus.fall_en = '1;
    drive('0, '0, '0, 1'b1);
    m_r = '0; m_f = '0; m_ovf = '0; m_valid = 1'b0; m_ch = 0; m_rise = 1'b0; m_last = N - 1;

    // r, p, n, rdy, v, ch, rise
    tbl.push_back('{1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 4'h4, 4'h0, 1'b1, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 2, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 0, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 2, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 3, 1'b1});
    tbl.push_back('{1'b0, 4'h9, 4'h0, 1'b1, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 0, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 3, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 4'h2, 4'h0, 1'b1, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1, 1'b1});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 0, 1'b0});

    foreach (tbl[i]) begin
      rst = tbl[i].r;
      drive(tbl[i].p, tbl[i].n, '0, tbl[i].rdy);
      cycle();
      check($sformatf("vec%0d_valid", i), bus.evt_valid, tbl[i].v);
      if (tbl[i].v || tbl[i].r) begin
        check($sformatf("vec%0d_ch", i), bus.evt_ch, tbl[i].ch);
        check($sformatf("vec%0d_rising", i), bus.evt_rising, tbl[i].rise);
      end
    end
    rst = 1'b0;

    // Both edges on one channel: rising first, falling on the next visit
    do_reset();
    xfer_q.delete();
    drive(4'b0110, 4'b0010, '0, 1'b1);
    cycle();
    idle(6, 1'b1);
    check("both_count", xfer_q.size(), 3);
    if (xfer_q.size() == 3) begin
      check("both_0", xfer_q[0], 3);
      check("both_1", xfer_q[1], 5);
      check("both_2", xfer_q[2], 2);
    end

    // Overflow while ch0 is held in OFFER and ch3 stays pending
    do_reset();
    xfer_q.delete();
    drive(4'b0001, '0, '0, 1'b0); cycle();
    idle(1, 1'b0);
    drive(4'b1000, '0, '0, 1'b0); cycle();
    check("ovf_first_pulse", bus.ovf_sticky, 4'b0000);
    idle(2, 1'b0);
    drive(4'b1000, '0, '0, 1'b0); cycle();
    check("ovf_set", bus.ovf_sticky, 4'b1000);
    idle(6, 1'b1);
    check("ovf_xfer_count", xfer_q.size(), 2);
    if (xfer_q.size() == 2) begin
      check("ovf_xfer_0", xfer_q[0], 1);
      check("ovf_xfer_1", xfer_q[1], 7);
    end
    drive(4'b0100, '0, '0, 1'b0); cycle();
    idle(1, 1'b0);
    drive(4'b1000, '0, '0, 1'b0); cycle();
    drive(4'b1000, '0, 4'b1000, 1'b0); cycle();
    check("ovf_clr_vs_set", bus.ovf_sticky, 4'b1000);
    drive('0, '0, 4'b1000, 1'b0); cycle();
    check("ovf_clr_alone", bus.ovf_sticky, 4'b0000);
    idle(5, 1'b1);

    // Disabled falling edge produces nothing
    do_reset();
    xfer_q.delete();
    bus.fall_en = 4'b1110;
    drive('0, 4'b0001, '0, 1'b1); cycle();
    idle(5, 1'b1);
    check("mask_no_event", xfer_q.size(), 0);
    check("mask_valid", bus.evt_valid, 1'b0);
    bus.fall_en = '1;

    // Reset mid-OFFER drops everything, pulses during reset ignored
    drive(4'b0110, '0, '0, 1'b0); cycle();
    idle(1, 1'b0);
    check("pre_rst_valid", bus.evt_valid, 1'b1);
    rst = 1'b1;
    drive(4'b1000, 4'b0001, '0, 1'b0); cycle();
    rst = 1'b0;
    check("rst_valid", bus.evt_valid, 1'b0);
    xfer_q.delete();
    idle(8, 1'b1);
    check("post_rst_no_event", xfer_q.size(), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        bus.rise_en = N'($urandom) | N'($urandom);
        bus.fall_en = N'($urandom) | N'($urandom);
      end
      rst = ($urandom_range(0, 499) == 0);
      drive(N'($urandom) & N'($urandom) & N'($urandom),
            N'($urandom) & N'($urandom) & N'($urandom),
            ($urandom_range(0, 7) == 0) ? N'($urandom) : '0,
            $urandom_range(0, 3) != 0);
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/edge_event_arb.md
# edge_event_arb

Collects synchronized rising/falling edge pulses from `NUM_CH` edge-detector channels, latches them as pending events, and serializes them onto a single valid/ready event stream using round-robin arbitration across channels. It sits directly downstream of the per-pin edge detectors and feeds a single consumer such as an interrupt/status block or a JTAG-visible event FIFO. Per-channel enables select which edge types are captured. Per-channel sticky flags report overflow, meaning an event lost while the same event was still pending.

## Interface
- `NUM_CH`, default 4: number of channels, range 2..32.
- `ID_W`, derived as `$clog2(NUM_CH)` and not overridable: width of the channel id.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `posedge_in`  in  NUM_CH  one-cycle rising-edge pulses, already synchronized to `clk`.
- `negedge_in`  in  NUM_CH  one-cycle falling-edge pulses, already synchronized to `clk`.
- `rise_en`  in  NUM_CH  capture enable for rising events, per channel.
- `fall_en`  in  NUM_CH  capture enable for falling events, per channel.
- `evt_valid`  out  1  event offered to the consumer.
- `evt_ready`  in  1  consumer accepts the event.
- `evt_ch`  out  ID_W  channel id of the offered event.
- `evt_rising`  out  1  1 = rising event, 0 = falling event.
- `ovf_sticky`  out  NUM_CH  per-channel overflow flag.
- `ovf_clr`  in  NUM_CH  per-channel overflow clear pulse.

## Operation
- **Pending state.** Two registers, `pend_r[NUM_CH]` and `pend_f[NUM_CH]`.
  - `pend_r[i]` is set when `posedge_in[i] & rise_en[i]`.
  - `pend_f[i]` is set when `negedge_in[i] & fall_en[i]`.
- **Enable changes.** Clearing an enable masks only new pulses. Bits already pending stay pending and are delivered.
- **State machine.**
  - States are IDLE (`evt_valid`=0) and OFFER (`evt_valid`=1).
  - IDLE -> OFFER: any pending bit is set. The arbiter winner is loaded into `evt_ch`/`evt_rising` and its pending bit is cleared on the same edge.
  - OFFER with `evt_ready`=0: hold. `evt_ch` and `evt_rising` are stable.
  - OFFER with `evt_ready`=1 and a pending bit set: load the next winner, stay in OFFER. This gives back-to-back transfers at 1 event/cycle.
  - OFFER with `evt_ready`=1 and nothing pending: go to IDLE.
- **Arbitration.**
  - Round-robin pointer `last` holds the most recently granted channel.
  - The search starts at `last+1` modulo `NUM_CH` and picks the first channel with `pend_r|pend_f` set. On a grant, `last` is updated to that channel.
  - If both `pend_r[i]` and `pend_f[i]` are set, rising is granted first. The falling event waits for the next round-robin visit to channel i.
- **Simultaneous set and clear.**
  - If a new enabled pulse arrives on the same cycle its pending bit is cleared by a load, the bit stays set (set wins).
  - That case is not an overflow.
- **Overflow.**
  - An enabled pulse arriving while its pending bit is already set, and that bit is not being cleared this cycle, sets `ovf_sticky[i]`. The event is dropped.
  - `ovf_clr[i]` clears the flag. If set and clear occur in the same cycle, set wins.
- **Reset.** While `rst` is high at a clock edge:
  - pend_r/pend_f = 0, state = IDLE, `evt_valid` = 0, `evt_ch` = 0, `evt_rising` = 0, `ovf_sticky` = 0.
  - `last` = NUM_CH-1, so channel 0 has first priority.
  - Reset asserted mid-OFFER drops the offered event and everything pending. Pulses present during a reset cycle are ignored.

## Timing
- Pulse at edge-to-edge cycle t -> pending bit set at the end of t -> `evt_valid`/payload registered high in cycle t+2. Minimum latency is 2 cycles.
- All outputs are registered. No combinational path from `evt_ready`, `posedge_in` or `negedge_in` to any output.
- A transfer occurs on a clock edge where `evt_valid & evt_ready`.
- Payload changes only on a transfer edge or on the IDLE->OFFER edge.
- Sustained throughput is 1 event/cycle while events are pending and `evt_ready`=1.
- `ovf_sticky` is updated 1 cycle after the offending pulse.

## Test plan
- **Single event.**
  - Stimulus: NUM_CH=4, all enables 1, `evt_ready`=1, `posedge_in`=4'b0100 for 1 cycle.
  - Required: `evt_valid`=1 exactly 2 cycles later for 1 cycle, with `evt_ch`=2, `evt_rising`=1. Then IDLE.
- **Round-robin order.**
  - Stimulus: `posedge_in`=4'b1111 for 1 cycle, `evt_ready`=1.
  - Required: 4 consecutive transfers with ch 0,1,2,3. Then `posedge_in`=4'b1001 -> ch 0, then 3.
- **Backpressure.**
  - Stimulus: `evt_ready`=0 for 5 cycles with an event offered.
  - Required: `evt_valid`, `evt_ch` and `evt_rising` hold stable. Raising `evt_ready` gives exactly one transfer.
- **Both edges on one channel.**
  - Stimulus: `posedge_in[1]` and `negedge_in[1]` in the same cycle, plus `posedge_in[2]`.
  - Required: order is (1,rise), (2,rise), (1,fall).
- **Overflow and clear.**
  - Stimulus: `evt_ready`=0, two `posedge_in[3]` pulses 3 cycles apart.
  - Required: `ovf_sticky`=4'b1000, and only one ch3 event is delivered.
  - Then: `ovf_clr[3]` pulse together with a new overflow pulse -> flag stays 1. `ovf_clr[3]` alone -> flag 0.
- **Enable mask and reset.**
  - Stimulus: `fall_en[0]`=0 with `negedge_in[0]` pulsed.
  - Required: no event.
  - Then: with an event pending and offered, assert `rst` for 1 cycle -> `evt_valid`=0, all pending cleared, no later events.
